// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns, digit-array type, dp constant
// and the leading-zero blanking mask helper.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic DP_OFF = 1'b1;

    // Index 0 is the ones digit, index 3 the thousands digit.
    typedef logic [3:0][3:0] bcd_digits_t;

    // Bit n set means digit n is a leading zero; digit 0 is never blanked.
    function automatic logic [3:0] lz_mask(input bcd_digits_t d);
        logic [3:0] m;
        m[3] = (d[3] == 4'd0);
        m[2] = m[3] && (d[2] == 4'd0);
        m[1] = m[2] && (d[1] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder ({g,f,e,d,c,b,a});
// codes 10-15 decode to blank.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_scan_display.sv
// 4-digit multiplexed common-anode display driver with frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module bcd_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_tick
);
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_TC = PW'(CLK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    bcd_digits_t   disp_q, disp_d;
    bcd_digits_t   pend_dig_q, pend_dig_d;
    logic          pend_q, pend_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q;
    logic          tick_q;

    bcd_digits_t   in_digits;
    logic          tc, boundary;
    logic [6:0]    raw_seg;
    logic [3:0]    blank;

    assign in_digits = {thousands, hundreds, tens, ones};
    assign tc        = (pcnt_q == PCNT_TC);
    assign boundary  = tc && (idx_q == 2'd3);

    always_comb begin
        pcnt_d     = tc ? '0 : pcnt_q + 1'b1;
        idx_d      = tc ? idx_q + 2'd1 : idx_q;
        disp_d     = disp_q;
        pend_dig_d = pend_dig_q;
        pend_d     = pend_q;
        if (load && boundary) begin
            // A load landing exactly on the boundary goes straight to the display.
            disp_d = in_digits;
            pend_d = 1'b0;
        end else begin
            if (boundary && pend_q) begin
                disp_d = pend_dig_q;
                pend_d = 1'b0;
            end
            if (load) begin
                pend_dig_d = in_digits;
                pend_d     = 1'b1;
            end
        end
    end

    // Outputs are decoded from next-state so seg/an line up with idx_q.
    bcd_to_seg7 u_dec (
        .bcd_i (disp_d[idx_d]),
        .seg_o (raw_seg)
    );

`ifdef SEG_LZ_BLANK_EN
    assign blank = lz_mask(disp_d);
`else
    assign blank = 4'b0000;
`endif

    always_comb begin
        seg_d = blank[idx_d] ? SEG_BLANK : raw_seg;
        an_d  = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q     <= '0;
            idx_q      <= 2'd0;
            disp_q     <= '0;
            pend_dig_q <= '0;
            pend_q     <= 1'b0;
            seg_q      <= SEG_BLANK;
            an_q       <= 4'b1111;
            dp_q       <= DP_OFF;
            tick_q     <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_dig_q <= pend_dig_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= DP_OFF;
            tick_q     <= boundary;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;
endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Downstream consumer of the 10-bit binary-to-BCD converter. Latches the four low BCD digits (thousands, hundreds, tens, ones) and time-multiplexes them onto a 4-digit common-anode 7-segment display. Provides a refresh prescaler, tear-free frame-aligned updates and a frame tick. The board's display output stage.

## Interface
- `CLK_DIV`, default 50000: clock cycles each digit is lit; legal range ≥ 2.
- `clk` in 1: the single system clock.
- `rst` in 1: synchronous, active-high reset.
- `thousands` in 4: BCD digit 3.
- `hundreds` in 4: BCD digit 2.
- `tens` in 4: BCD digit 1.
- `ones` in 4: BCD digit 0.
- `load` in 1: single-cycle strobe; captures the four digit inputs.
- `seg` out 7: `{g,f,e,d,c,b,a}`, active low.
- `an` out 4: digit enables, active low; `an[0]` is ones.
- `dp` out 1: decimal point, active low; constant 1 (off).
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

Clock and reset are decided: one clock, `clk`; reset `rst` is synchronous and active-high.

## Operation
- **Prescaler** `pcnt` counts 0..CLK_DIV-1 and wraps. At terminal count (TC), digit index `idx` (2 bits) advances 0→1→2→3→0.
- **Frame boundary:** the TC cycle with `idx`=3.
- **Pending register:**
  - `load` copies the four inputs into `pend_digits` and sets `pend`.
  - A `load` while `pend` is set overwrites `pend_digits` (last load wins).
- **Display update:** at a frame boundary with `pend` set, `disp_digits` ← `pend_digits` and `pend` clears.
  - `load` coincident with a frame boundary bypasses the pending register: `disp_digits` takes the inputs on that edge and `pend` stays 0.
- **Decode:** `seg` is the 7-segment pattern of `disp_digits[idx]`.
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Codes 10–15 are invalid BCD: seg=0x7F (blank).
- **Anodes:** `an` = ~(1 << `idx`). Exactly one digit is enabled at any time after the first post-reset cycle.
- **Frame tick:** `frame_tick`=1 in the cycle following each frame boundary edge, i.e. the first cycle the new frame is shown.

## Timing
- `seg`, `an`, `dp` and `frame_tick` are all registered. `seg` and `an` change on the same edge, so there is no cross-digit ghosting.
- **Reset values:**
  - `pcnt`=0, `idx`=0, `disp_digits`=0, `pend_digits`=0, `pend`=0.
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_tick`=0.
- First cycle after `rst` deasserts: `an`=4'b1110, `seg`=0x40 (ones digit, value 0).
- Each digit is lit for exactly CLK_DIV cycles; a frame lasts 4·CLK_DIV cycles.
- **Update latency:** a `load` reaches the display at the next frame boundary, at most 4·CLK_DIV cycles later. The digit inputs need only be valid in the `load` cycle.
- **Reset mid-frame or mid-pending:** `rst` wins over all other events. Any pending update is discarded.
- `load` held high for several cycles is treated as repeated loads; the last one wins.

## Configuration
- **`SEG_LZ_BLANK_EN` defined:** leading-zero blanking.
  - Digit 3 is blanked if zero.
  - Digit 2 is blanked if it and digit 3 are zero.
  - Digit 1 is blanked if it, digit 2 and digit 3 are zero.
  - Digit 0 is never blanked.
  - Blanked digits output seg=0x7F; `an` still scans normally.
- **Not defined:** all four digits are always shown, including leading zeros.

## Structure
- **Shared package `seg7_pkg`:**
  - segment-pattern constants for 0–9 and blank;
  - a 4×4-bit BCD digit-array typedef;
  - the `dp`-off constant.
- **Sub-module `bcd_to_seg7`:** combinational 4-bit BCD to 7-bit active-low pattern; codes 10–15 give blank.
- The top level holds the prescaler, scan counter, pending/display registers, blanking logic and output registers.

## Test plan
All scenarios use CLK_DIV=4.
1. **Reset:** hold `rst` 3 cycles → `an`=1111, `seg`=7F, `dp`=1, `frame_tick`=0. First post-reset cycle → `an`=1110, `seg`=40.
2. **Basic load:** `load` 1,0,2,3 mid-frame → after the next frame boundary `idx`0..3 show 30, 24, 40, 79 with `an`=1110, 1101, 1011, 0111, each held 4 cycles. `frame_tick` pulses once per 16 cycles.
3. **Overwrite and bypass:**
   - two loads (0,0,0,5 then 0,9,9,9) in one frame → only 999 is shown;
   - `load` 0,1,2,3 on a boundary cycle → shown in the immediately following frame.
4. **Invalid code:** `ones`=4'hC → `seg`=7F during `idx`0; other digits unaffected.
5. **Blanking, `SEG_LZ_BLANK_EN` defined:** load 0,0,0,7 → digits 3–1 show 7F, digit 0 shows 78. Load 0,0,0,0 → digit 0 shows 40.
6. **Reset with update pending:** `load` 1,0,0,0 then `rst` before the boundary → display stays all zeros (with blanking: 7F, 7F, 7F, 40).
